mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data/address width; legal values are 32 and 64.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum bus-wait cycles; 0 disables the timeout.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005 STALL  in  1  SHALL be the global pipeline hold.
REQ-006 FLUSH  in  1  SHALL be the bubble-insert request.
REQ-007 A_VALID/A_PC[XLEN]/A_INST[32]/A_REG_D[5]/A_REG_D_V[XLEN]  in  SHALL be the execute-stage instruction, destination and ALU result.
REQ-008 A_LOAD_RDEN/A_LOAD_SIZE[2]/A_LOAD_SIGNED/A_STORE_WREN/A_ADDR[XLEN]/A_STORE_DATA[XLEN]  in  SHALL be the memory-op controls (size 0=byte, 1=half, 2=word, 3=dword).
REQ-009 MEM_REQ/MEM_WE  out  1, MEM_ADDR  out  XLEN, MEM_STRB  out  XLEN/8, MEM_WDATA  out  XLEN  SHALL be the data-bus request.
REQ-010 MEM_ACK  in  1, MEM_RDATA  in  XLEN  SHALL be the bus completion and read data.
REQ-011 BUSY  out  1  SHALL request that upstream stages hold.
REQ-012 M_VALID/M_PC/M_INST/M_REG_D/M_REG_D_V/M_ERR  out  SHALL be the writeback-stage result; M_ERR flags misalignment or timeout.

Function
REQ-013 Priority SHALL be RST > busy (state ACCESS) > STALL > FLUSH > capture.
REQ-014 Capture: in IDLE with no STALL and no FLUSH, all A_* SHALL be latched into stage registers.
REQ-015 FLUSH in IDLE without STALL SHALL latch a bubble (valid, rden, wren, reg_d, err all 0).
REQ-016 FSM states SHALL be IDLE and ACCESS; a captured valid op with rden or wren that is aligned SHALL enter ACCESS on the next edge.
REQ-017 In ACCESS, MEM_REQ SHALL be 1 with MEM_ADDR/MEM_WE/MEM_STRB/MEM_WDATA stable until MEM_ACK is sampled high.
REQ-018 On MEM_ACK, a load SHALL register the formatted MEM_RDATA into reg_d_v; the FSM SHALL return to IDLE.
REQ-019 BUSY SHALL equal (state==ACCESS); STALL and FLUSH SHALL be ignored while BUSY.
REQ-020 M_VALID SHALL equal valid AND state==IDLE; non-memory ops have 1-cycle latency, memory ops 1 + wait cycles + 1.
REQ-021 Byte offset = A_ADDR[log2(XLEN/8)-1:0]; load data SHALL be MEM_RDATA shifted right by offset*8, truncated to size, then sign-extended if LOAD_SIGNED, else zero-extended.
REQ-022 Store STRB SHALL be the size mask (1, 3, F, FF) shifted left by offset; WDATA SHALL replicate the low size bytes across all lanes.
REQ-023 When XLEN=32, size 3 SHALL be treated as word.
REQ-024 Misaligned (offset not a multiple of the size in bytes): no bus request, M_ERR=1, M_REG_D=0, 1-cycle latency.
REQ-025 A wait counter SHALL count ACCESS cycles; when it reaches TIMEOUT (non-zero) without ACK, MEM_REQ SHALL drop, state SHALL return to IDLE, M_ERR=1 and M_REG_D=0.
REQ-026 An ACK arriving in the same cycle as timeout expiry SHALL win (normal completion).
REQ-027 MEM_ACK sampled outside ACCESS SHALL be ignored.

Reset
REQ-028 On RST, all stage registers, outputs, state (IDLE) and counter SHALL be 0 immediately, including mid-transaction (MEM_REQ drops asynchronously).

Structure
REQ-029 Package mem_pkg SHALL hold the size encodings, the FSM state type and the strobe-mask constants.
REQ-030 Sub-module mem_lane_fmt SHALL implement the combinational load extraction/extension and the store strobe/replication logic.

Verification
REQ-031 XLEN=32, LB signed, ADDR=0x1003, RDATA=0x80FF_0000, ACK after 0 waits -> M_REG_D_V=0xFFFF_FF80, M_VALID 2 cycles after capture.
REQ-032 SH ADDR=0x2002, DATA=0x0000_BEEF -> MEM_STRB=0xC, MEM_WDATA=0xBEEF_BEEF, MEM_WE=1.
REQ-033 LW ADDR=0x2001 -> no MEM_REQ, M_ERR=1, M_REG_D=0 next cycle.
REQ-034 TIMEOUT=4, no ACK -> MEM_REQ high 4 cycles, then M_ERR=1, BUSY falls.
REQ-035 FLUSH and STALL asserted during a 3-cycle wait -> ignored; load completes; the next FLUSH without STALL yields M_VALID=0.
REQ-036 RST asserted mid-ACCESS -> MEM_REQ=0 and BUSY=0 without a clock edge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
// Size encodings, FSM state type, strobe masks and alignment helpers.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // A 32-bit datapath has no dword lane, so dword collapses to word.
  function automatic logic [1:0] eff_size(
    input logic [1:0] sz,
    input logic       is64
  );
    return (!is64 && sz == SZ_D) ? SZ_W : sz;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    unique case (sz)
      SZ_B: m = 1'b0;
      SZ_H: m = off[0];
      SZ_W: m = |off[1:0];
      SZ_D: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: load extraction/extension,
// store strobe generation and write-data replication.
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                    size,
  input  logic [$clog2(XLEN/8)-1:0]     off,
  input  logic                          sgn,
  input  logic [XLEN-1:0]               rdata,
  input  logic [XLEN-1:0]               sdata,
  output logic [XLEN-1:0]               ldata,
  output logic [XLEN/8-1:0]             strb,
  output logic [XLEN-1:0]               wdata
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ext_w;
  logic [NB-1:0]   mask;

  assign sh = rdata >> {off, 3'b000};

  if (XLEN == 64) begin : g_w64
    assign ext_w = {{(XLEN-32){sgn & sh[31]}}, sh[31:0]};
  end else begin : g_w32
    assign ext_w = sh;
  end

  always_comb begin
    ldata = sh;
    wdata = sdata;
    mask  = NB'(STRB_D);
    unique case (size)
      SZ_B: begin
        ldata = {{(XLEN-8){sgn & sh[7]}}, sh[7:0]};
        wdata = {NB{sdata[7:0]}};
        mask  = NB'(STRB_B);
      end
      SZ_H: begin
        ldata = {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
        wdata = {(NB/2){sdata[15:0]}};
        mask  = NB'(STRB_H);
      end
      SZ_W: begin
        ldata = ext_w;
        wdata = {(NB/4){sdata[31:0]}};
        mask  = NB'(STRB_W);
      end
      SZ_D: begin
        ldata = sh;
        wdata = sdata;
        mask  = NB'(STRB_D);
      end
    endcase
  end

  assign strb = mask << off;

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: captures execute results,
// runs one data-bus transaction per load/store, feeds writeback.
module mem_access
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              A_VALID,
  input  logic [XLEN-1:0]   A_PC,
  input  logic [31:0]       A_INST,
  input  logic [4:0]        A_REG_D,
  input  logic [XLEN-1:0]   A_REG_D_V,
  input  logic              A_LOAD_RDEN,
  input  logic [1:0]        A_LOAD_SIZE,
  input  logic              A_LOAD_SIGNED,
  input  logic              A_STORE_WREN,
  input  logic [XLEN-1:0]   A_ADDR,
  input  logic [XLEN-1:0]   A_STORE_DATA,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [XLEN-1:0]   MEM_ADDR,
  output logic [XLEN/8-1:0] MEM_STRB,
  output logic [XLEN-1:0]   MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [XLEN-1:0]   MEM_RDATA,
  output logic              BUSY,
  output logic              M_VALID,
  output logic [XLEN-1:0]   M_PC,
  output logic [31:0]       M_INST,
  output logic [4:0]        M_REG_D,
  output logic [XLEN-1:0]   M_REG_D_V,
  output logic              M_ERR
);

  localparam int OW = $clog2(XLEN/8);

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rdv_q, rdv_d;
  logic            rden_q, rden_d;
  logic            wren_q, wren_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0]   ldata;
  logic [XLEN/8-1:0] strb;
  logic [XLEN-1:0]   wdata;
  logic [1:0]        a_size;
  logic              a_mem;
  logic              a_mis;
  logic              acc;

  mem_lane_fmt #(.XLEN(XLEN)) u_fmt (
    .size  (size_q),
    .off   (addr_q[OW-1:0]),
    .sgn   (sgn_q),
    .rdata (MEM_RDATA),
    .sdata (sdata_q),
    .ldata (ldata),
    .strb  (strb),
    .wdata (wdata)
  );

  assign a_size = eff_size(A_LOAD_SIZE, XLEN == 64);
  assign a_mem  = A_VALID & (A_LOAD_RDEN | A_STORE_WREN);
  assign a_mis  = misaligned(a_size, 3'(A_ADDR[OW-1:0]));
  assign acc    = (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    rd_d    = rd_q;
    rdv_d   = rdv_q;
    rden_d  = rden_q;
    wren_d  = wren_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_ACCESS: begin
        // ACK beats an expiring timeout in the same cycle.
        if (MEM_ACK) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (rden_q) rdv_d = ldata;
        end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (!STALL && FLUSH) begin
          valid_d = 1'b0;
          rden_d  = 1'b0;
          wren_d  = 1'b0;
          rd_d    = '0;
          err_d   = 1'b0;
        end else if (!STALL) begin
          valid_d = A_VALID;
          pc_d    = A_PC;
          inst_d  = A_INST;
          rd_d    = (a_mem && a_mis) ? 5'd0 : A_REG_D;
          rdv_d   = A_REG_D_V;
          rden_d  = A_LOAD_RDEN;
          wren_d  = A_STORE_WREN;
          size_d  = a_size;
          sgn_d   = A_LOAD_SIGNED;
          addr_d  = A_ADDR;
          sdata_d = A_STORE_DATA;
          err_d   = a_mem && a_mis;
          cnt_d   = '0;
          if (a_mem && !a_mis) state_d = ST_ACCESS;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      rd_q    <= '0;
      rdv_q   <= '0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rd_q    <= rd_d;
      rdv_q   <= rdv_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      err_q   <= err_d;
    end
  end

  assign MEM_REQ   = acc;
  assign MEM_WE    = acc & wren_q;
  assign MEM_ADDR  = acc ? addr_q : '0;
  assign MEM_STRB  = acc ? strb : '0;
  assign MEM_WDATA = (acc && wren_q) ? wdata : '0;
  assign BUSY      = acc;

  assign M_VALID   = valid_q & ~acc;
  assign M_PC      = pc_q;
  assign M_INST    = inst_q;
  assign M_REG_D   = rd_q;
  assign M_REG_D_V = rdv_q;
  assign M_ERR     = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access (XLEN=32, TIMEOUT=4): vector table,
// directed corner sequences and a randomized reference-model run.
module tb_mem_access;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL, FLUSH;
  logic        A_VALID;
  logic [31:0] A_PC, A_INST;
  logic [4:0]  A_REG_D;
  logic [31:0] A_REG_D_V;
  logic        A_LOAD_RDEN;
  logic [1:0]  A_LOAD_SIZE;
  logic        A_LOAD_SIGNED, A_STORE_WREN;
  logic [31:0] A_ADDR, A_STORE_DATA;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_STRB;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        BUSY, M_VALID;
  logic [31:0] M_PC, M_INST;
  logic [4:0]  M_REG_D;
  logic [31:0] M_REG_D_V;
  logic        M_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access #(.XLEN(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .A_VALID(A_VALID), .A_PC(A_PC), .A_INST(A_INST),
    .A_REG_D(A_REG_D), .A_REG_D_V(A_REG_D_V),
    .A_LOAD_RDEN(A_LOAD_RDEN), .A_LOAD_SIZE(A_LOAD_SIZE),
    .A_LOAD_SIGNED(A_LOAD_SIGNED), .A_STORE_WREN(A_STORE_WREN),
    .A_ADDR(A_ADDR), .A_STORE_DATA(A_STORE_DATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_STRB(MEM_STRB), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY),
    .M_VALID(M_VALID), .M_PC(M_PC), .M_INST(M_INST),
    .M_REG_D(M_REG_D), .M_REG_D_V(M_REG_D_V), .M_ERR(M_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: byte-level arithmetic on sizes and offsets.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd,
    input int off, input int n, input logic sg);
    longint unsigned v, lim;
    lim = 64'd1 << (8 * n);
    v = (64'(rd) >> (8 * off)) % lim;
    if (sg && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input int off, input int n);
    int m;
    m = ((1 << n) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d,
                                            input int n);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic idle_inputs();
    A_VALID = 0; A_LOAD_RDEN = 0; A_STORE_WREN = 0;
    MEM_ACK = 0; STALL = 0; FLUSH = 0;
  endtask

  task automatic drive(input logic ld, input logic st,
    input logic [1:0] sz, input logic sg, input logic [31:0] addr,
    input logic [31:0] data, input logic [31:0] alu);
    A_VALID = 1; A_PC = addr ^ 32'h4000; A_INST = 32'h0000_2003;
    A_REG_D = 5'd7; A_REG_D_V = alu;
    A_LOAD_RDEN = ld; A_STORE_WREN = st; A_LOAD_SIZE = sz;
    A_LOAD_SIGNED = sg; A_ADDR = addr; A_STORE_DATA = data;
  endtask

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] res;
  } vec_t;

  vec_t vt[13];

  initial begin
    int cyc;
    logic [31:0] alu;

    vt[0]  = '{1'b1, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_0000, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80};
    vt[1]  = '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0080};
    vt[2]  = '{1'b1, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h80FF_0000, 1'b0, 4'h0, 32'h0, 32'hFFFF_80FF};
    vt[3]  = '{1'b1, 2'd1, 1'b0, 32'h1000, 32'h0, 32'h1234_ABCD, 1'b0, 4'h0, 32'h0, 32'h0000_ABCD};
    vt[4]  = '{1'b1, 2'd2, 1'b1, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF};
    vt[5]  = '{1'b1, 2'd3, 1'b0, 32'h1004, 32'h0, 32'hCAFE_F00D, 1'b0, 4'h0, 32'h0, 32'hCAFE_F00D};
    vt[6]  = '{1'b1, 2'd1, 1'b1, 32'h1000, 32'h0, 32'h0000_7FFF, 1'b0, 4'h0, 32'h0, 32'h0000_7FFF};
    vt[7]  = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0, 1'b0, 4'hC, 32'hBEEF_BEEF, 32'h1111_1111};
    vt[8]  = '{1'b0, 2'd0, 1'b0, 32'h2001, 32'h1234_5678, 32'h0, 1'b0, 4'h2, 32'h7878_7878, 32'h1111_1111};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h2000, 32'hA5A5_0F0F, 32'h0, 1'b0, 4'hF, 32'hA5A5_0F0F, 32'h1111_1111};
    vt[10] = '{1'b1, 2'd2, 1'b0, 32'h2001, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    vt[11] = '{1'b0, 2'd1, 1'b0, 32'h2003, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    vt[12] = '{1'b1, 2'd0, 1'b1, 32'h1001, 32'h0, 32'h0000_7F00, 1'b0, 4'h0, 32'h0, 32'h0000_007F};

    idle_inputs();
    A_PC = 0; A_INST = 0; A_REG_D = 0; A_REG_D_V = 0;
    A_LOAD_SIZE = 0; A_LOAD_SIGNED = 0; A_ADDR = 0;
    A_STORE_DATA = 0; MEM_RDATA = 0;
    RST = 1;
    tick(); tick();
    chk("rst_mvalid", M_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_req", MEM_REQ, 0);
    chk("rst_regdv", M_REG_D_V, 0);
    RST = 0;
    tick();

    // Vector table: zero-wait acknowledge.
    foreach (vt[i]) begin
      drive(vt[i].ld, !vt[i].ld, vt[i].sz, vt[i].sg, vt[i].addr,
            vt[i].data, 32'h1111_1111);
      tick();
      A_VALID = 0;
      if (vt[i].err) begin
        chk($sformatf("v%0d_noreq", i), MEM_REQ, 0);
        chk($sformatf("v%0d_mvalid", i), M_VALID, 1);
        chk($sformatf("v%0d_err", i), M_ERR, 1);
        chk($sformatf("v%0d_regd", i), M_REG_D, 0);
      end else begin
        chk($sformatf("v%0d_req", i), MEM_REQ, 1);
        chk($sformatf("v%0d_we", i), MEM_WE, !vt[i].ld);
        chk($sformatf("v%0d_addr", i), MEM_ADDR, vt[i].addr);
        chk($sformatf("v%0d_mv0", i), M_VALID, 0);
        if (!vt[i].ld) begin
          chk($sformatf("v%0d_strb", i), MEM_STRB, vt[i].strb);
          chk($sformatf("v%0d_wdata", i), MEM_WDATA, vt[i].wdata);
        end
        MEM_RDATA = vt[i].rdata;
        MEM_ACK = 1;
        tick();
        MEM_ACK = 0;
        chk($sformatf("v%0d_mvalid", i), M_VALID, 1);
        chk($sformatf("v%0d_busy", i), BUSY, 0);
        chk($sformatf("v%0d_err", i), M_ERR, 0);
        chk($sformatf("v%0d_regd", i), M_REG_D, 7);
        chk($sformatf("v%0d_res", i), M_REG_D_V, vt[i].res);
      end
      tick();
    end

    // Non-memory op with a stray ACK: one-cycle latency, ACK ignored.
    drive(0, 0, 2'd2, 0, 32'h3000, 0, 32'h0BAD_F00D);
    A_REG_D = 5'd3; MEM_ACK = 1; MEM_RDATA = 32'hFFFF_FFFF;
    tick();
    A_VALID = 0; MEM_ACK = 0;
    chk("nm_mvalid", M_VALID, 1);
    chk("nm_busy", BUSY, 0);
    chk("nm_regd", M_REG_D, 3);
    chk("nm_regdv", M_REG_D_V, 32'h0BAD_F00D);
    chk("nm_pc", M_PC, 32'h7000);
    tick();

    // Timeout with no ACK.
    drive(1, 0, 2'd2, 0, 32'h4000, 0, 0);
    tick();
    A_VALID = 0;
    cyc = 0;
    for (int k = 0; k < 20 && MEM_REQ; k++) begin
      cyc++;
      tick();
    end
    chk("to_req_cycles", cyc, TO);
    chk("to_busy", BUSY, 0);
    chk("to_mvalid", M_VALID, 1);
    chk("to_err", M_ERR, 1);
    chk("to_regd", M_REG_D, 0);
    tick();

    // ACK on the expiry cycle wins.
    drive(1, 0, 2'd2, 0, 32'h4004, 0, 0);
    tick();
    A_VALID = 0;
    tick(); tick(); tick();
    chk("tie_req", MEM_REQ, 1);
    MEM_RDATA = 32'h1357_9BDF; MEM_ACK = 1;
    tick();
    MEM_ACK = 0;
    chk("tie_err", M_ERR, 0);
    chk("tie_mvalid", M_VALID, 1);
    chk("tie_res", M_REG_D_V, 32'h1357_9BDF);
    tick();

    // STALL/FLUSH during a 3-cycle wait are ignored.
    drive(1, 0, 2'd1, 1, 32'h5002, 0, 0);
    tick();
    A_VALID = 0; STALL = 1; FLUSH = 1;
    for (int k = 0; k < 3; k++) begin
      chk("sf_busy", BUSY, 1);
      tick();
    end
    MEM_RDATA = 32'h9ABC_0000; MEM_ACK = 1;
    tick();
    MEM_ACK = 0;
    chk("sf_mvalid", M_VALID, 1);
    chk("sf_res", M_REG_D_V, 32'hFFFF_9ABC);
    tick();
    chk("sf_stall_hold", M_VALID, 1);
    STALL = 0;
    tick();
    chk("sf_flush_bubble", M_VALID, 0);
    chk("sf_flush_regd", M_REG_D, 0);
    FLUSH = 0;
    tick();

    // Asynchronous reset mid-transaction.
    drive(1, 0, 2'd2, 0, 32'h6000, 0, 0);
    tick();
    A_VALID = 0;
    chk("ar_req_before", MEM_REQ, 1);
    #2 RST = 1;
    #1;
    chk("ar_req", MEM_REQ, 0);
    chk("ar_busy", BUSY, 0);
    RST = 0;
    tick();

    // Randomized transactions against the reference model.
    for (int t = 0; t < 300; t++) begin
      int op, off, n, w, lat;
      logic [1:0] sz;
      logic sg, mis, mem, ld, terr;
      logic [31:0] addr, sd, rd;
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      addr = $urandom;
      sd = $urandom; rd = $urandom; alu = $urandom;
      w = $urandom_range(0, 5);
      off = int'(addr[1:0]);
      n = nbytes(sz);
      ld = (op == 1);
      mem = (op != 0);
      mis = mem && (off % n != 0);
      drive(ld, op == 2, sz, sg, addr, sd, alu);
      MEM_RDATA = rd;
      tick();
      A_VALID = 0;
      terr = mis;
      if (mem && !mis) begin
        chk("r_addr", MEM_ADDR, addr);
        if (!ld) begin
          chk("r_strb", MEM_STRB, ref_strb(off, n));
          chk("r_wdata", MEM_WDATA, ref_wdata(sd, n));
        end
        lat = (w < TO) ? w + 1 : TO;
        terr = (w >= TO);
        cyc = 0;
        for (int c = 0; c < 12; c++) begin
          MEM_ACK = (c == w);
          tick();
          MEM_ACK = 0;
          cyc++;
          if (!BUSY) break;
        end
        chk("r_latency", cyc, lat);
      end
      chk("r_mvalid", M_VALID, 1);
      chk("r_err", M_ERR, terr);
      chk("r_regd", M_REG_D, terr ? 5'd0 : 5'd7);
      if (!terr)
        chk("r_res", M_REG_D_V, ld ? ref_load(rd, off, n, sg) : alu);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
